prog_instr_memory: RTL and testbench

PROG_INSTR_MEMORY -- requirements
Module: prog_instr_memory

---
 rtl/prog_instr_memory_if.sv | 30 +++
 rtl/prog_instr_memory.sv | 190 +++++++++++++++++++
 tb/tb_prog_instr_memory.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_instr_memory_if.sv
// Load/fetch bus of the program instruction memory.
// The master side fills the memory and issues fetches; the memory itself is the slave.
interface prog_instr_memory_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
);
  logic              LoadStart;
  logic              LoadValid;
  logic              LoadLast;
  logic [DATA_W-1:0] LoadData;
  logic              LoadReady;
  logic              LoadDone;
  logic [AW:0]       WordCount;
  logic              FetchReq;
  logic [31:0]       PC;
  logic              FetchReady;
  logic [DATA_W-1:0] Instr;
  logic              InstrValid;
  logic              Fault;

  modport master (
    output LoadStart, LoadValid, LoadLast, LoadData, FetchReq, PC,
    input  LoadReady, LoadDone, WordCount, FetchReady, Instr, InstrValid, Fault
  );

  modport slave (
    input  LoadStart, LoadValid, LoadLast, LoadData, FetchReq, PC,
    output LoadReady, LoadDone, WordCount, FetchReady, Instr, InstrValid, Fault
  );
endinterface

// File: rtl/prog_instr_memory.sv
// Program instruction memory: streamed load with zero-fill of the unused tail,
// and a pipelined fetch port with READ_LAT (1 or 2) cycles of latency.
module prog_instr_memory #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  prog_instr_memory_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam logic [AW-1:0] WP_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WP_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  // Misaligned or beyond the array: any low byte-offset bit or any bit above the index.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != 32'd0);
  endfunction

  state_t            state_r;
  logic [AW-1:0]     wp_r;
  logic [AW:0]       count_r;
  logic [AW:0]       word_count_r;
  logic              load_ready_r;
  logic              load_done_r;
  logic              fetch_ready_r;
  logic [DATA_W-1:0] mem_r [DEPTH] = '{default: '0};

  logic              beat_s;
  logic              wp_last_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              accept_s;
  logic              fault_s;
  logic [AW-1:0]     idx_s;

  assign beat_s    = (state_r == LOAD) && bus.LoadValid && load_ready_r;
  assign wp_last_s = (wp_r == WP_LAST);
  assign accept_s  = bus.FetchReq && fetch_ready_r;
  assign fault_s   = pc_fault(bus.PC);
  assign idx_s     = bus.PC[AW+1:2];

  // Write-port select: load beats carry data, FILL writes zeros.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_wdata_s = '0;
    if (beat_s) begin
      mem_we_s    = 1'b1;
      mem_wdata_s = bus.LoadData;
    end else if (state_r == FILL) begin
      mem_we_s    = 1'b1;
      mem_wdata_s = '0;
    end else begin
      mem_we_s    = 1'b0;
      mem_wdata_s = '0;
    end
  end

  // Memory array write; deliberately unreset so contents survive Reset_n.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[wp_r] <= mem_wdata_s;
    end
  end

  // Load FSM with registered handshake and completion outputs.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= IDLE;
      wp_r          <= '0;
      count_r       <= '0;
      word_count_r  <= '0;
      load_ready_r  <= 1'b0;
      load_done_r   <= 1'b0;
      fetch_ready_r <= 1'b1;
    end else begin
      load_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.LoadStart) begin
            state_r       <= LOAD;
            wp_r          <= '0;
            count_r       <= '0;
            load_ready_r  <= 1'b1;
            fetch_ready_r <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_s) begin
            count_r <= count_r + CNT_ONE;
            // A beat landing in the final word ends the load whatever LoadLast says.
            if (wp_last_s) begin
              state_r       <= IDLE;
              load_ready_r  <= 1'b0;
              fetch_ready_r <= 1'b1;
              load_done_r   <= 1'b1;
              word_count_r  <= count_r + CNT_ONE;
            end else if (bus.LoadLast) begin
              state_r      <= FILL;
              load_ready_r <= 1'b0;
              wp_r         <= wp_r + WP_ONE;
            end else begin
              wp_r <= wp_r + WP_ONE;
            end
          end
        end
        FILL: begin
          if (wp_last_s) begin
            state_r       <= IDLE;
            fetch_ready_r <= 1'b1;
            load_done_r   <= 1'b1;
            word_count_r  <= count_r;
          end else begin
            wp_r <= wp_r + WP_ONE;
          end
        end
        default: begin
          state_r       <= IDLE;
          load_ready_r  <= 1'b0;
          fetch_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.LoadReady  = load_ready_r;
  assign bus.LoadDone   = load_done_r;
  assign bus.WordCount  = word_count_r;
  assign bus.FetchReady = fetch_ready_r;

  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_data_r;
  logic              s1_fault_r;

  // First fetch stage: array read at acceptance, so a fetch alongside LoadStart sees old data.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_fault_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_fault_r <= fault_s;
        s1_data_r  <= fault_s ? '0 : mem_r[idx_s];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              out_valid_r;
      logic [DATA_W-1:0] out_data_r;
      logic              out_fault_r;

      // Second fetch stage; data and fault hold between valid returns.
      always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          out_fault_r <= 1'b0;
        end else begin
          out_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            out_data_r  <= s1_data_r;
            out_fault_r <= s1_fault_r;
          end
        end
      end

      assign bus.InstrValid = out_valid_r;
      assign bus.Instr      = out_data_r;
      assign bus.Fault      = out_fault_r;
    end else begin : g_lat1
      assign bus.InstrValid = s1_valid_r;
      assign bus.Instr      = s1_data_r;
      assign bus.Fault      = s1_fault_r;
    end
  endgenerate

endmodule

// File: tb/tb_prog_instr_memory.sv
// Directed bench: READ_LAT=1 and READ_LAT=2 instances receive identical stimulus.
module tb_prog_instr_memory;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = 32'd0;

  int checks = 0;
  int fails = 0;
  int n;

  logic [31:0] a_w [3] = '{32'hA0A0_0001, 32'hA1A1_0002, 32'hA2A2_0003};
  logic [31:0] exp_w [4];

  prog_instr_memory_if #(.DATA_W(32), .AW(7)) bus1 ();
  prog_instr_memory_if #(.DATA_W(32), .AW(7)) bus2 ();

  assign bus1.LoadStart = load_start;
  assign bus1.LoadValid = load_valid;
  assign bus1.LoadLast  = load_last;
  assign bus1.LoadData  = load_data;
  assign bus1.FetchReq  = fetch_req;
  assign bus1.PC        = pc;
  assign bus2.LoadStart = load_start;
  assign bus2.LoadValid = load_valid;
  assign bus2.LoadLast  = load_last;
  assign bus2.LoadData  = load_data;
  assign bus2.FetchReq  = fetch_req;
  assign bus2.PC        = pc;

  prog_instr_memory #(.DATA_W(32), .DEPTH(128), .READ_LAT(1)) dut1 (
    .CLK(CLK), .Reset_n(Reset_n), .bus(bus1)
  );
  prog_instr_memory #(.DATA_W(32), .DEPTH(128), .READ_LAT(2)) dut2 (
    .CLK(CLK), .Reset_n(Reset_n), .bus(bus2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_load_ready", 32'(bus1.LoadReady), 32'd0);
    chk("rst_load_done", 32'(bus1.LoadDone), 32'd0);
    chk("rst_word_count", 32'(bus1.WordCount), 32'd0);
    chk("rst_instr_valid", 32'(bus1.InstrValid), 32'd0);
    chk("rst_instr", bus1.Instr, 32'd0);
    chk("rst_fault", 32'(bus1.Fault), 32'd0);
    chk("rst_instr_valid2", 32'(bus2.InstrValid), 32'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk("rel_fetch_ready", 32'(bus1.FetchReady), 32'd1);

    // Short load: three beats then zero-fill of the remaining 125 words.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready", 32'(bus1.LoadReady), 32'd1);
    chk("load_fetch_ready", 32'(bus1.FetchReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = a_w[i];
      load_last  = (i == 2);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("fill_load_ready", 32'(bus1.LoadReady), 32'd0);
    n = 0;
    while (bus1.LoadDone !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("fill_cycles", 32'(n), 32'd125);
    chk("short_word_count", 32'(bus1.WordCount), 32'd3);
    chk("done_fetch_ready", 32'(bus1.FetchReady), 32'd1);

    fetch_req = 1'b1;
    pc = 32'h8;
    tick();
    chk("done_pulse_end", 32'(bus1.LoadDone), 32'd0);
    chk("f8_valid", 32'(bus1.InstrValid), 32'd1);
    chk("f8_instr", bus1.Instr, a_w[2]);
    chk("f8_fault", 32'(bus1.Fault), 32'd0);
    pc = 32'hC;
    tick();
    chk("fc_instr", bus1.Instr, 32'd0);
    chk("fc_fault", 32'(bus1.Fault), 32'd0);
    chk("fc_valid", 32'(bus1.InstrValid), 32'd1);
    fetch_req = 1'b0;
    tick();
    chk("idle_valid", 32'(bus1.InstrValid), 32'd0);
    tick();

    // Back-to-back fetches; READ_LAT=2 returns them two cycles later, in order.
    exp_w = '{a_w[0], a_w[1], a_w[2], 32'd0};
    for (int i = 0; i < 6; i++) begin
      fetch_req = (i < 4);
      pc = (i < 4) ? 32'(4 * i) : 32'd0;
      tick();
      chk("lat2_valid", 32'(bus2.InstrValid), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 4) chk("lat2_instr", bus2.Instr, exp_w[i-1]);
      chk("lat1_valid", 32'(bus1.InstrValid), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("lat1_instr", bus1.Instr, exp_w[i]);
    end

    fetch_req = 1'b1;
    pc = 32'h4;
    tick();
    chk("f4_instr", bus1.Instr, a_w[1]);
    fetch_req = 1'b0;
    tick();
    chk("hold_valid", 32'(bus1.InstrValid), 32'd0);
    chk("hold_instr", bus1.Instr, a_w[1]);

    // Misaligned and out-of-range fetches.
    fetch_req = 1'b1;
    pc = 32'h202;
    tick();
    chk("f202_instr", bus1.Instr, 32'd0);
    chk("f202_fault", 32'(bus1.Fault), 32'd1);
    pc = 32'h200;
    tick();
    chk("f200_instr", bus1.Instr, 32'd0);
    chk("f200_fault", 32'(bus1.Fault), 32'd1);
    chk("f200_valid", 32'(bus1.InstrValid), 32'd1);
    pc = 32'h0;
    tick();
    chk("f0_instr", bus1.Instr, a_w[0]);
    chk("f0_fault", 32'(bus1.Fault), 32'd0);
    fetch_req = 1'b0;
    tick();
    tick();

    // Fetch with LoadStart, then a full 128-beat load without LoadLast.
    fetch_req  = 1'b1;
    pc         = 32'h0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("ls_fetch_valid", 32'(bus1.InstrValid), 32'd1);
    chk("ls_fetch_instr", bus1.Instr, a_w[0]);
    chk("ls_fetch_ready", 32'(bus1.FetchReady), 32'd0);
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hB000_0000 + 32'(i);
      tick();
      if (i == 0) chk("inflight_valid2", 32'(bus2.InstrValid), 32'd1);
      if (i == 0) chk("inflight_instr2", bus2.Instr, a_w[0]);
      if (i == 63) chk("mid_fetch_ready", 32'(bus1.FetchReady), 32'd0);
    end
    chk("full_done", 32'(bus1.LoadDone), 32'd1);
    chk("full_word_count", 32'(bus1.WordCount), 32'd128);
    chk("full_load_ready", 32'(bus1.LoadReady), 32'd0);
    chk("full_fetch_ready", 32'(bus1.FetchReady), 32'd1);
    tick();
    chk("full_done_end", 32'(bus1.LoadDone), 32'd0);
    chk("full_no_accept", 32'(bus1.LoadReady), 32'd0);
    chk("full_count_hold", 32'(bus1.WordCount), 32'd128);
    load_valid = 1'b0;
    fetch_req = 1'b1;
    pc = 32'h1FC;
    tick();
    chk("f1fc_instr", bus1.Instr, 32'hB000_007F);
    chk("f1fc_fault", 32'(bus1.Fault), 32'd0);
    pc = 32'h0;
    tick();
    chk("fb0_instr", bus1.Instr, 32'hB000_0000);
    fetch_req = 1'b0;
    tick();

    // Reset in the middle of a load keeps the beats already written.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    load_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_load_ready", 32'(bus1.LoadReady), 32'd0);
    chk("mid_rst_done", 32'(bus1.LoadDone), 32'd0);
    chk("mid_rst_word_count", 32'(bus1.WordCount), 32'd0);
    chk("mid_rst_instr", bus1.Instr, 32'd0);
    chk("mid_rst_fetch_ready", 32'(bus1.FetchReady), 32'd1);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst_fetch_ready", 32'(bus1.FetchReady), 32'd1);
    chk("post_rst_done", 32'(bus1.LoadDone), 32'd0);
    chk("post_rst_load_ready", 32'(bus1.LoadReady), 32'd0);
    fetch_req = 1'b1;
    pc = 32'h10;
    tick();
    chk("post_rst_done2", 32'(bus1.LoadDone), 32'd0);
    chk("f10_instr", bus1.Instr, 32'hC000_0004);
    pc = 32'h14;
    tick();
    chk("f14_instr", bus1.Instr, 32'hB000_0005);
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
